// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared sample types and the round/shift/saturate helper
// Purpose: common definitions for the FIR output path.
//   SAMPLE_W        : width of a raw FIR output sample
//   sample_t        : signed raw sample type
//   rss_t           : result of round_shift_sat (value + saturation flag)
//   round_shift_sat : round-half-up, arithmetic shift right, clamp to out_w bits
package fir_pkg;

  localparam int SAMPLE_W = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] value;
    logic                       sat;
  } rss_t;

  // Working width is one bit wider than the sample so the rounding add can
  // never overflow. The clamped value fits in out_w bits; callers keep the
  // low out_w bits of .value.
  function automatic rss_t round_shift_sat(input sample_t sample,
                                           input int      shift,
                                           input int      out_w);
    logic signed [SAMPLE_W:0] acc;
    logic signed [SAMPLE_W:0] max_v;
    logic signed [SAMPLE_W:0] min_v;
    rss_t                     r;
    acc = {sample[SAMPLE_W-1], sample};
    if (shift > 0) begin
      acc = acc + ((SAMPLE_W+1)'(1) <<< (shift - 1));
    end
    acc   = acc >>> shift;
    max_v = ((SAMPLE_W+1)'(1) <<< (out_w - 1)) - (SAMPLE_W+1)'(1);
    min_v = -max_v - (SAMPLE_W+1)'(1);
    r.sat = 1'b0;
    if (acc > max_v) begin
      acc   = max_v;
      r.sat = 1'b1;
    end else if (acc < min_v) begin
      acc   = min_v;
      r.sat = 1'b1;
    end
    r.value = acc[SAMPLE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - pointer-based synchronous FIFO
// Purpose: small output buffer; a push at full is accepted when a pop happens
// in the same cycle.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push         : write push_data (accepted if not full or popping)
//   push_data    : data to write
//   pop          : remove head entry (ignored when empty)
//   pop_data     : head entry, 0 when empty
//   full, empty  : occupancy status
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Gating with empty keeps the head at 0 during and right after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fir_output_decimator.sv
// rtl/fir_output_decimator.sv - decimate, scale, saturate and buffer FIR output
// Purpose: keeps every DECIM-th valid FIR sample, scales it by 2^-SHIFT with
// round-half-up, saturates to OUT_W bits and queues it for a valid/ready sink.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid, in_data    : FIR output stream (no backpressure)
//   out_valid, out_ready : output handshake
//   out_data             : FIFO head sample
//   clear_flags          : clears sat_sticky, ovf_sticky, drop_count
//   sat_sticky           : a kept sample was clamped
//   ovf_sticky           : a kept sample was dropped on a full FIFO
//   drop_count           : dropped samples, saturating at 255
module fir_output_decimator #(
  parameter int DECIM      = 4,
  parameter int SHIFT      = 8,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic signed [31:0]      in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  input  logic                    clear_flags,
  output logic                    sat_sticky,
  output logic                    ovf_sticky,
  output logic [7:0]              drop_count
);

  import fir_pkg::*;

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PW-1:0]           phase;
  logic                    keep;
  rss_t                    rss;
  logic signed [OUT_W-1:0] scaled;
  logic                    s1_valid;
  logic signed [OUT_W-1:0] s1_data;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    drop;

  assign keep   = in_valid && (phase == '0);
  assign rss    = round_shift_sat(in_data, SHIFT, OUT_W);
  assign scaled = rss.value[OUT_W-1:0];

  // Upper bits are only sign copies after clamping.
  if (OUT_W < SAMPLE_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^rss.value[SAMPLE_W-1:OUT_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= keep;
      if (keep) s1_data <= scaled;
    end
  end

  fir_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (s1_valid),
    .push_data (s1_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  // Full implies non-empty, so out_ready alone decides whether a pop frees a slot.
  assign drop      = s1_valid && fifo_full && !out_ready;

  // Set/increment events take priority over clear_flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_sticky <= 1'b0;
      ovf_sticky <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (keep && rss.sat)  sat_sticky <= 1'b1;
      else if (clear_flags) sat_sticky <= 1'b0;

      if (drop) begin
        ovf_sticky <= 1'b1;
        if (clear_flags)               drop_count <= 8'd1;
        else if (drop_count != 8'hFF)  drop_count <= drop_count + 8'd1;
      end else if (clear_flags) begin
        ovf_sticky <= 1'b0;
        drop_count <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_fir_output_decimator.sv
// tb/tb_fir_output_decimator.sv - randomized and directed bench with reference model
`timescale 1ns/1ps
module tb_fir_output_decimator;

  localparam int SHIFT = 8;
  localparam int OUT_W = 16;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [31:0] in_data = '0;
  logic               out_ready = 1'b0;
  logic               clear_flags = 1'b0;

  logic               a_ov, a_sat, a_ovf, b_ov, b_sat, b_ovf;
  logic signed [15:0] a_od, b_od;
  logic [7:0]         a_dc, b_dc;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  fir_output_decimator #(.DECIM(4), .SHIFT(SHIFT), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .clear_flags(clear_flags),
    .sat_sticky(a_sat), .ovf_sticky(a_ovf), .drop_count(a_dc));

  fir_output_decimator #(.DECIM(1), .SHIFT(SHIFT), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .clear_flags(clear_flags),
    .sat_sticky(b_sat), .ovf_sticky(b_ovf), .drop_count(b_dc));

  // Reference model state, index 0 = DECIM 4 instance, 1 = DECIM 1 instance.
  int  m_count[2];
  bit  m_pv[2];
  int  m_pd[2];
  bit  m_sat[2];
  bit  m_ovf[2];
  int  m_drop[2];
  int  q0[$];
  int  q1[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decim_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qhead(input int k);
    if (qsize(k) == 0) return 0;
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  // floor((x + 2^(S-1)) / 2^S) with plain integer division, then clamp.
  task automatic ref_scale(input logic signed [31:0] x, output int val, output bit sat);
    longint v, d, q, hi, lo;
    v = longint'(x);
    d = longint'(1) << SHIFT;
    if (SHIFT > 0) v = v + d / 2;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    hi  = (longint'(1) << (OUT_W - 1)) - 1;
    lo  = -hi - 1;
    sat = (q > hi) || (q < lo);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    val = int'(q);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_count[k] = 0; m_pv[k] = 0; m_pd[k] = 0;
      m_sat[k] = 0; m_ovf[k] = 0; m_drop[k] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock edge with the inputs that were held during the cycle.
  task automatic model_edge(input int k);
    bit pop, drop, kept, s;
    int val;
    pop  = (qsize(k) > 0) && out_ready;
    drop = 0;
    if (pop) begin
      if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (m_pv[k]) begin
      if (qsize(k) < DEPTH) begin
        if (k == 0) q0.push_back(m_pd[k]); else q1.push_back(m_pd[k]);
      end else begin
        drop = 1;
      end
    end
    if (drop) begin
      m_ovf[k]  = 1;
      m_drop[k] = clear_flags ? 1 : ((m_drop[k] < 255) ? m_drop[k] + 1 : 255);
    end else if (clear_flags) begin
      m_ovf[k]  = 0;
      m_drop[k] = 0;
    end
    kept = in_valid && ((m_count[k] % decim_of(k)) == 0);
    ref_scale(in_data, val, s);
    if (kept && s) m_sat[k] = 1;
    else if (clear_flags) m_sat[k] = 0;
    m_pv[k] = kept;
    m_pd[k] = val;
    if (in_valid) m_count[k] = m_count[k] + 1;
  endtask

  task automatic check_all();
    logic [15:0] e0, e1;
    e0 = 16'(qhead(0));
    e1 = 16'(qhead(1));
    check_eq("a.out_valid", {31'b0, a_ov}, {31'b0, qsize(0) > 0});
    if (qsize(0) > 0) check_eq("a.out_data", {16'b0, a_od}, {16'b0, e0});
    check_eq("a.sat_sticky", {31'b0, a_sat}, {31'b0, m_sat[0]});
    check_eq("a.ovf_sticky", {31'b0, a_ovf}, {31'b0, m_ovf[0]});
    check_eq("a.drop_count", {24'b0, a_dc}, 32'(m_drop[0]));
    check_eq("b.out_valid", {31'b0, b_ov}, {31'b0, qsize(1) > 0});
    if (qsize(1) > 0) check_eq("b.out_data", {16'b0, b_od}, {16'b0, e1});
    check_eq("b.sat_sticky", {31'b0, b_sat}, {31'b0, m_sat[1]});
    check_eq("b.ovf_sticky", {31'b0, b_ovf}, {31'b0, m_ovf[1]});
    check_eq("b.drop_count", {24'b0, b_dc}, 32'(m_drop[1]));
  endtask

  task automatic step(input bit iv, input logic signed [31:0] d, input bit rdy, input bit clr);
    in_valid = iv; in_data = d; out_ready = rdy; clear_flags = clr;
    @(posedge clk);
    if (reset_n) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 32'sd0, rdy, 0);
  endtask

  initial begin
    logic signed [31:0] dv;
    model_reset();
    #1;
    check_all();
    check_eq("reset.a_out_data", {16'b0, a_od}, 32'd0);
    check_eq("reset.b_out_data", {16'b0, b_od}, 32'd0);
    idle(2, 1);
    reset_n = 1'b1;

    // Ramp 256*n: DECIM 4 keeps n = 0,4,8,12.
    for (int n = 0; n < 16; n++) step(1, 32'(256 * n), 1, 0);
    idle(3, 1);

    // Rounding at half-way points.
    step(1, 32'sd383, 1, 0);
    step(1, 32'sd384, 1, 0);
    step(1, -32'sd384, 1, 0);
    step(1, -32'sd385, 1, 0);
    idle(3, 1);

    // Saturation at both ends, then clear.
    step(1, 32'h7FFF_FFFF, 1, 0);
    step(1, 32'h8000_0000, 1, 0);
    idle(2, 1);
    check_eq("sat.b_sticky_set", {31'b0, b_sat}, 32'd1);
    step(0, 32'sd0, 1, 1);
    check_eq("sat.b_sticky_clr", {31'b0, b_sat}, 32'd0);
    idle(3, 1);

    // Overflow: six samples into a stalled 4-entry FIFO.
    for (int n = 1; n <= 6; n++) step(1, 32'(256 * n), 0, 0);
    step(0, 32'sd0, 0, 0);
    check_eq("ovf.b_drop_count", {24'b0, b_dc}, 32'd2);
    check_eq("ovf.b_ovf_sticky", {31'b0, b_ovf}, 32'd1);
    idle(6, 1);

    // Push and pop together at full: no drop.
    for (int n = 1; n <= 5; n++) step(1, 32'(256 * n), 0, 0);
    step(0, 32'sd0, 1, 0);
    check_eq("full_pp.b_drop_count", {24'b0, b_dc}, 32'd2);
    idle(6, 1);

    // Drop coinciding with clear_flags: the drop wins.
    for (int n = 1; n <= 5; n++) step(1, 32'(256 * n), 0, 0);
    step(0, 32'sd0, 0, 1);
    check_eq("clr_drop.b_drop_count", {24'b0, b_dc}, 32'd1);
    idle(6, 1);

    // Buffer samples, stop with DECIM 4 phase at 2, then asynchronous reset.
    for (int n = 0; n < 8; n++) begin
      step(1, 32'(256 * (n + 1)), 0, 0);
      if (n >= 2 && (m_count[0] % 4) == 2) break;
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("async.a_out_valid", {31'b0, a_ov}, 32'd0);
    check_eq("async.b_out_valid", {31'b0, b_ov}, 32'd0);
    check_eq("async.b_drop_count", {24'b0, b_dc}, 32'd0);
    check_eq("async.a_out_data", {16'b0, a_od}, 32'd0);
    idle(2, 1);
    reset_n = 1'b1;
    step(1, 32'sd512, 1, 0);
    step(0, 32'sd0, 1, 0);
    check_eq("async.first_kept_valid", {31'b0, a_ov}, 32'd1);
    check_eq("async.first_kept_data", {16'b0, a_od}, 32'd2);
    idle(2, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) dv = $urandom;
      else dv = 32'($urandom_range(0, 1 << 21)) - 32'sd1048576;
      step($urandom_range(0, 3) != 0, dv, $urandom_range(0, 9) < 7,
           $urandom_range(0, 15) == 0);
    end
    idle(8, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fir_output_decimator.md
Name: fir_output_decimator

Overview:
- Sits directly downstream of the direct-form FIR filter and consumes its 32-bit signed output stream, one sample per clock when valid.
- Keeps every DECIM-th sample and scales it by 2^-SHIFT with round-half-up.
- Saturates the result to OUT_W bits signed and buffers it in a small FIFO behind a valid/ready interface.
- Reports saturation and FIFO-overflow drops through sticky flags and a drop counter.

Parameters:
- DECIM, 4: decimation factor; must be >= 1; 1 keeps every sample.
- SHIFT, 8: arithmetic right-shift amount; range 0..31; 0 means no rounding add.
- OUT_W, 16: output sample width, signed; range 2..32.
- FIFO_DEPTH, 4: output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data carries a FIR output sample this cycle
- in_data  in  32  signed FIR output sample
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  OUT_W  signed decimated, scaled, saturated sample (FIFO head)
- clear_flags  in  1  synchronous clear of sat_sticky, ovf_sticky and drop_count
- sat_sticky  out  1  set when any kept sample saturated
- ovf_sticky  out  1  set when any kept sample was dropped because the FIFO was full
- drop_count  out  8  number of dropped samples, saturating at 255

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- While reset_n = 0, all of the following hold immediately, without waiting for a clock edge:
  - FIFO empty, out_valid = 0, out_data = 0.
  - Phase counter = 0; pipeline register invalid.
  - sat_sticky = 0, ovf_sticky = 0, drop_count = 0.
- Reset may assert mid-operation; all buffered samples are discarded.
- No input backpressure: the block cannot stall the FIR.
- Phase counter:
  - Range 0..DECIM-1; advances only on cycles with in_valid = 1 and wraps from DECIM-1 to 0.
  - A sample is kept when in_valid = 1 and phase = 0.
  - The first valid sample after reset is kept.
- Arithmetic on a kept sample:
  - Sign-extend in_data to 33 bits.
  - Add 2^(SHIFT-1) when SHIFT > 0.
  - Arithmetic shift right by SHIFT, which floors.
  - Clamp to the range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - If clamping occurs, set sat_sticky.
- Pipeline:
  - Stage 1 register holds the scaled value plus a valid bit, loaded on the edge ending the input cycle.
  - Stage 2 writes the FIFO on the next edge.
  - Latency with an empty FIFO: a kept sample at input cycle N appears with out_valid = 1 in cycle N+2.
- FIFO:
  - Pop when out_valid && out_ready.
  - A push is accepted when the FIFO is not full, or when a pop occurs in the same cycle; simultaneous push and pop at full is lossless.
  - Otherwise the sample is dropped: ovf_sticky is set and drop_count increments, holding at 255.
  - Output order is strictly FIFO.
  - out_data shows the head entry and holds stable while out_valid && !out_ready.
- Flag clearing: clear_flags clears the stickies and drop_count on the next edge. If a set/increment event occurs in the same cycle, the event wins (sticky = 1, drop_count = 1).
- Widths: all arithmetic is in 33 bits signed, so no intermediate overflow occurs.

Decomposition:
- Package fir_pkg:
  - SAMPLE_W = 32 constant.
  - sample_t typedef, logic signed [31:0].
  - Function round_shift_sat(sample, shift, out_w) returning value and saturation bit; shared with later scaler stages.
- One sub-module, fir_sync_fifo (parameters WIDTH, DEPTH), same clk/reset_n:
  - Pointer-based, with full/empty outputs and push/pop inputs.
  - Implements the same-cycle push+pop-at-full rule.

Test Plan:
1. DECIM=4, SHIFT=8, out_ready=1; in_data = 256*n for n=0..15, valid every cycle from cycle 0 -> out_data 0,4,8,12 with out_valid in cycles 2,6,10,14 only.
2. DECIM=1, SHIFT=8; inputs 383, 384, -384, -385 -> outputs 1, 2, -1, -2; sat_sticky stays 0.
3. DECIM=1, SHIFT=8, OUT_W=16; inputs 0x7FFF_FFFF, 0x8000_0000 -> outputs 0x7FFF, 0x8000; sat_sticky = 1. Assert clear_flags -> sat_sticky = 0 next cycle.
4. DECIM=1, out_ready=0; six valid samples 1..6 (scaled) -> FIFO holds 1..4, drop_count = 2, ovf_sticky = 1. Then out_ready=1 -> outputs 1,2,3,4 in order, then out_valid = 0.
5. FIFO full with out_ready=1 and a new kept sample in the same cycle -> pop and push both succeed, drop_count unchanged. Repeat with clear_flags and a drop in the same cycle -> drop_count = 1.
6. Three samples buffered, phase = 2; pull reset_n low between edges -> out_valid = 0 and drop_count = 0 without a clock edge. After release, the first valid sample is kept (phase restarted at 0).
